// File: rtl/cassette_fsk_encoder.sv
// +--------------------------------------------------------------------------+
// | cassette_fsk_encoder                                                     |
// | Serialises bytes into cassette FSK (leader, 10-bit frames, trailer).     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module cassette_fsk_encoder #(
    parameter int BIT_CYCLES   = 1024,
    parameter int LEADER_BITS  = 1200,
    parameter int TRAILER_BITS = 600
) (
    input  logic       clk,
    input  logic       nRST,
    input  logic       enable,
    input  logic [7:0] in_data,
    input  logic       in_last,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       cas_out,
    output logic       busy
);

    localparam int              c_PW         = $clog2(BIT_CYCLES);
    localparam logic [c_PW-1:0] c_PH_LAST    = c_PW'(BIT_CYCLES - 1);
    localparam logic [15:0]     c_LEAD_LAST  = 16'(LEADER_BITS - 1);
    localparam logic [15:0]     c_TRAIL_LAST = 16'(TRAILER_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LEADER  = 3'd1,
        S_FRAME   = 3'd2,
        S_FILL    = 3'd3,
        S_TRAILER = 3'd4
    } state_t;

    state_t          r_state;
    logic [c_PW-1:0] r_phase;
    logic [15:0]     r_bitcnt;
    logic [3:0]      r_idx;
    logic [7:0]      r_data;
    logic            r_last;
    logic            r_cas;

    logic            w_bit_end;
    logic            w_boundary;
    logic            w_ready;
    logic            w_take;
    logic            w_bit;
    logic            w_wave;
    logic [2:0]      w_didx;

    assign w_bit_end = (r_state != S_IDLE) && (r_phase == c_PH_LAST);
    assign w_didx    = 3'(r_idx - 4'd1);

    always_comb begin
        w_boundary = 1'b0;
        case (r_state)
            S_LEADER: w_boundary = w_bit_end && (r_bitcnt == c_LEAD_LAST);
            S_FRAME:  w_boundary = w_bit_end && (r_idx == 4'd9) && !r_last;
            S_FILL:   w_boundary = w_bit_end;
            default:  w_boundary = 1'b0;
        endcase
    end

    assign w_ready = enable && w_boundary;
    assign w_take  = w_ready && in_valid;

    always_comb begin
        w_bit = 1'b1;
        if (r_state == S_FRAME) begin
            case (r_idx)
                4'd0:    w_bit = 1'b0;
                4'd9:    w_bit = 1'b1;
                default: w_bit = r_data[w_didx];
            endcase
        end
    end

    // 0 bit: high for the first half; 1 bit: high for the first quarter of each half.
    assign w_wave = w_bit ? ~r_phase[c_PW-2] : ~r_phase[c_PW-1];

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            r_state  <= S_IDLE;
            r_phase  <= '0;
            r_bitcnt <= '0;
            r_idx    <= '0;
            r_data   <= '0;
            r_last   <= 1'b0;
            r_cas    <= 1'b0;
        end else if (!enable) begin
            r_state  <= S_IDLE;
            r_phase  <= '0;
            r_bitcnt <= '0;
            r_idx    <= '0;
            r_data   <= '0;
            r_last   <= 1'b0;
            r_cas    <= 1'b0;
        end else begin
            r_cas <= (r_state == S_IDLE) ? 1'b0 : w_wave;
            if (r_state != S_IDLE) begin
                r_phase <= r_phase + 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_state  <= S_LEADER;
                        r_phase  <= '0;
                        r_bitcnt <= '0;
                    end
                end
                S_LEADER: begin
                    if (w_bit_end) begin
                        if (r_bitcnt == c_LEAD_LAST) begin
                            r_bitcnt <= '0;
                            r_state  <= S_FILL;
                        end else begin
                            r_bitcnt <= r_bitcnt + 16'd1;
                        end
                    end
                end
                S_FRAME: begin
                    if (w_bit_end) begin
                        if (r_idx != 4'd9) begin
                            r_idx <= r_idx + 4'd1;
                        end else if (r_last) begin
                            r_state  <= S_TRAILER;
                            r_bitcnt <= '0;
                        end else begin
                            r_state <= S_FILL;
                        end
                    end
                end
                S_FILL: begin
                    r_state <= S_FILL;
                end
                S_TRAILER: begin
                    if (w_bit_end) begin
                        if (r_bitcnt == c_TRAIL_LAST) begin
                            r_state  <= S_IDLE;
                            r_bitcnt <= '0;
                            r_last   <= 1'b0;
                        end else begin
                            r_bitcnt <= r_bitcnt + 16'd1;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
            // An accepted byte overrides the FILL fallback chosen above.
            if (w_take) begin
                r_state <= S_FRAME;
                r_idx   <= 4'd0;
                r_data  <= in_data;
                r_last  <= in_last;
            end
        end
    end

    assign in_ready = w_ready;
    assign cas_out  = r_cas;
    assign busy     = (r_state != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_cassette_fsk_encoder.sv
// +--------------------------------------------------------------------------+
// | tb_cassette_fsk_encoder                                                  |
// | Bit-stream reference model and edge-interval decoder for the encoder.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_cassette_fsk_encoder;

    localparam int BC = 16;
    localparam int LB = 4;
    localparam int TB = 2;

    logic       clk = 1'b0;
    logic       nRST = 1'b0;
    logic       enable = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_last = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic       cas_out;
    logic       busy;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] tx_bytes[$];
    int         tx_fill[$];
    int         ready_cyc[$];
    logic       trace[$];

    cassette_fsk_encoder #(
        .BIT_CYCLES  (BC),
        .LEADER_BITS (LB),
        .TRAILER_BITS(TB)
    ) dut (
        .clk     (clk),
        .nRST    (nRST),
        .enable  (enable),
        .in_data (in_data),
        .in_last (in_last),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .cas_out (cas_out),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic wave(input logic b, input int p);
        return b ? ((p % (BC / 2)) < (BC / 4)) : (p < (BC / 2));
    endfunction

    // Recover bytes from the recorded line using only edge spacing.
    task automatic decode_check(input string name, input int n);
        int   edges[$];
        int   iv[$];
        logic db[$];
        logic [7:0] got[$];
        logic ok_iv;
        logic ok_stop;
        int   i;
        int   k;
        logic [7:0] v;
        for (int c = 1; c < trace.size(); c++)
            if (trace[c] !== trace[c-1]) edges.push_back(c);
        edges.push_back(trace.size());
        ok_iv = 1'b1;
        for (int e = 1; e < edges.size(); e++) begin
            iv.push_back(edges[e] - edges[e-1]);
            if (iv[e-1] != BC / 2 && iv[e-1] != BC / 4) ok_iv = 1'b0;
        end
        chk($sformatf("%s intervals", name), 32'(ok_iv), 32'd1);
        i = 0;
        while (i < iv.size()) begin
            if (iv[i] == BC / 2) begin db.push_back(1'b0); i += 2; end
            else begin db.push_back(1'b1); i += 4; end
        end
        k = 0;
        ok_stop = 1'b1;
        while (k < db.size()) begin
            if (db[k] === 1'b1) k++;
            else if (k + 9 < db.size()) begin
                for (int b = 0; b < 8; b++) v[b] = db[k+1+b];
                got.push_back(v);
                if (db[k+9] !== 1'b1) ok_stop = 1'b0;
                k += 10;
            end else begin
                ok_stop = 1'b0;
                k = db.size();
            end
        end
        chk($sformatf("%s stop bits", name), 32'(ok_stop), 32'd1);
        chk($sformatf("%s decoded count", name), 32'(got.size()), 32'(n));
        for (int j = 0; j < n && j < got.size(); j++)
            chk($sformatf("%s decoded byte %0d", name, j), 32'(got[j]), 32'(tx_bytes[j]));
    endtask

    // Build the expected bit stream, drive the handshake, check every cycle.
    task automatic run_tx(input string name);
        logic bits[$];
        bit   bnd[$];
        int   tcyc[$];
        logic vdrv[];
        logic [7:0] ddrv[];
        logic ldrv[];
        int   n;
        int   total;
        int   start;
        logic exp_cas;
        n = tx_bytes.size();
        for (int i = 0; i < LB; i++) begin bits.push_back(1'b1); bnd.push_back(i == LB - 1); end
        for (int i = 0; i < n; i++) begin
            for (int f = 0; f < tx_fill[i]; f++) begin bits.push_back(1'b1); bnd.push_back(1'b1); end
            tcyc.push_back(bits.size() * BC - 1);
            bits.push_back(1'b0); bnd.push_back(1'b0);
            for (int b = 0; b < 8; b++) begin bits.push_back(tx_bytes[i][b]); bnd.push_back(1'b0); end
            bits.push_back(1'b1); bnd.push_back(i != n - 1);
        end
        for (int i = 0; i < TB; i++) begin bits.push_back(1'b1); bnd.push_back(1'b0); end
        total = bits.size() * BC;
        vdrv = new[total + 1];
        ddrv = new[total + 1];
        ldrv = new[total + 1];
        for (int c = 0; c <= total; c++) begin
            vdrv[c] = 1'b0;
            ddrv[c] = 8'($urandom);
            ldrv[c] = 1'($urandom);
        end
        for (int i = 0; i < n; i++) begin
            if (tx_fill[i] == 0) start = (i == 0) ? 0 : tcyc[i-1] + 1;
            else start = tcyc[i] - int'($urandom_range(0, 10));
            for (int c = start; c <= tcyc[i]; c++) begin
                vdrv[c] = 1'b1;
                ddrv[c] = tx_bytes[i];
                ldrv[c] = (i == n - 1);
            end
        end
        ready_cyc.delete();
        trace.delete();
        @(negedge clk);
        enable   = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'($urandom);
        in_last  = 1'($urandom);
        for (int c = 0; c <= total; c++) begin
            @(negedge clk);
            trace.push_back(cas_out);
            exp_cas = (c == 0) ? 1'b0 : wave(bits[(c-1)/BC], (c-1) % BC);
            chk($sformatf("%s cas c=%0d", name, c), 32'(cas_out), 32'(exp_cas));
            chk($sformatf("%s busy c=%0d", name, c), 32'(busy), 32'(c < total));
            chk($sformatf("%s ready c=%0d", name, c), 32'(in_ready),
                32'((c < total) && (c % BC == BC - 1) && bnd[c/BC]));
            if (in_ready === 1'b1) ready_cyc.push_back(c);
            in_valid = vdrv[c];
            in_data  = ddrv[c];
            in_last  = ldrv[c];
        end
        decode_check(name, n);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("reset cas", 32'(cas_out), 32'd0);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset ready", 32'(in_ready), 32'd0);
        nRST = 1'b1;

        // valid offered while the motor is off must be ignored
        in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("disabled busy", 32'(busy), 32'd0);
            chk("disabled ready", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;

        // asynchronous reset in the middle of the leader
        @(negedge clk);
        enable   = 1'b1;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (18) @(negedge clk);
        chk("midleader busy", 32'(busy), 32'd1);
        chk("midleader cas", 32'(cas_out), 32'd1);
        #2 nRST = 1'b0;
        #1;
        chk("async reset cas", 32'(cas_out), 32'd0);
        chk("async reset busy", 32'(busy), 32'd0);
        chk("async reset ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        nRST   = 1'b1;
        enable = 1'b0;

        tx_bytes = '{8'hA5};
        tx_fill  = '{0};
        run_tx("a5");
        chk("a5 ready count", 32'(ready_cyc.size()), 32'd1);
        if (ready_cyc.size() >= 1) chk("a5 ready cycle", 32'(ready_cyc[0]), 32'(LB * BC - 1));

        tx_bytes = '{8'h00, 8'hFF};
        tx_fill  = '{0, 0};
        run_tx("b2b");
        chk("b2b ready count", 32'(ready_cyc.size()), 32'd2);
        if (ready_cyc.size() >= 2) chk("b2b spacing", 32'(ready_cyc[1] - ready_cyc[0]), 32'(10 * BC));

        tx_bytes = '{8'h3C, 8'h5A};
        tx_fill  = '{0, 2};
        run_tx("fill");
        chk("fill ready count", 32'(ready_cyc.size()), 32'd4);
        for (int i = 2; i < ready_cyc.size(); i++)
            chk($sformatf("fill spacing %0d", i), 32'(ready_cyc[i] - ready_cyc[i-1]), 32'(BC));

        for (int r = 0; r < 4; r++) begin
            int n;
            n = int'($urandom_range(1, 3));
            tx_bytes.delete();
            tx_fill.delete();
            for (int i = 0; i < n; i++) begin
                tx_bytes.push_back(8'($urandom));
                tx_fill.push_back(int'($urandom_range(0, 2)));
            end
            run_tx($sformatf("rand%0d", r));
        end

        // abort during data bit 4 of 0x81
        @(negedge clk);
        enable   = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h81;
        in_last  = 1'b1;
        for (int c = 0; c <= 150; c++) begin
            @(negedge clk);
            chk($sformatf("abort ready c=%0d", c), 32'(in_ready), 32'(c == LB * BC - 1));
            if (c == 150) begin
                chk("abort busy before", 32'(busy), 32'd1);
                enable = 1'b0;
            end
        end
        @(negedge clk);
        chk("abort busy", 32'(busy), 32'd0);
        chk("abort cas", 32'(cas_out), 32'd0);
        chk("abort ready", 32'(in_ready), 32'd0);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("abort hold busy", 32'(busy), 32'd0);
            chk("abort hold ready", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;

        tx_bytes = '{8'h81};
        tx_fill  = '{0};
        run_tx("restart");
        chk("restart ready count", 32'(ready_cyc.size()), 32'd1);
        if (ready_cyc.size() >= 1) chk("restart leader", 32'(ready_cyc[0]), 32'(LB * BC - 1));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
